// File: rtl/lcd_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_frame_scheduler
//  Description : Front-end for the HD44780 4-bit character driver. Holds the
//                4x16 character frame buffer, arbitrates round-robin writes
//                from two requesters, tracks buffer changes, and fires the
//                driver's print trigger once the driver is idle.
//                Optional feature macro: LCD_SCHED_PERIODIC_EN (forces a
//                re-print after REFRESH_PERIOD idle cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_frame_scheduler #(
    parameter int MAX_BURST      = 16,
    parameter int ACK_TIMEOUT    = 8,
    parameter int REFRESH_PERIOD = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req,
    input  logic [5:0] a_addr,
    input  logic [7:0] a_data,
    output logic       a_gnt,
    input  logic       b_req,
    input  logic [5:0] b_addr,
    input  logic [7:0] b_data,
    output logic       b_gnt,
    input  logic       lcd_busy,
    output logic       lcd_trg,
    input  logic [5:0] lcd_addr,
    output logic [7:0] lcd_data,
    output logic       dirty
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int ACK_W   = $clog2(ACK_TIMEOUT + 1);

    localparam logic [7:0]         c_SPACE     = 8'h20;
    localparam logic [BURST_W-1:0] c_BURST_MAX = BURST_W'(MAX_BURST);
    localparam logic [ACK_W-1:0]   c_ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TRIG = 2'd1,
        S_ACK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           mem_q [64];
    logic [7:0]           mem_d [64];
    logic                 last_b_q, last_b_d;   // 1: B held the most recent grant
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [ACK_W-1:0]     ack_cnt_q, ack_cnt_d;
    logic                 dirty_q, dirty_d;
    logic                 trg_q, trg_d;

    logic                 w_grant_ok;
    logic                 w_go_trig;
    logic                 w_we;
    logic [5:0]           w_waddr;
    logic [7:0]           w_wdata;
    logic                 w_refresh;

    // Grant arbitration and the IDLE->TRIG decision; grants are masked in reset
    always_comb begin
        w_grant_ok = rst && (state_q == S_IDLE) && !lcd_busy && (burst_q < c_BURST_MAX);
        a_gnt      = w_grant_ok && a_req && (!b_req || last_b_q);
        b_gnt      = w_grant_ok && b_req && (!a_req || !last_b_q);
        w_we       = a_gnt || b_gnt;
        w_waddr    = a_gnt ? a_addr : b_addr;
        w_wdata    = a_gnt ? a_data : b_data;
        // A pending write outranks printing until the burst limit is hit
        w_go_trig  = (state_q == S_IDLE) && dirty_q && !lcd_busy &&
                     ((!a_req && !b_req) || (burst_q == c_BURST_MAX));
    end

`ifdef LCD_SCHED_PERIODIC_EN
    localparam int IDLE_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [IDLE_W-1:0] c_IDLE_LAST = IDLE_W'(REFRESH_PERIOD - 1);

    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

    // Idle-time counter; wraps and flags a refresh every REFRESH_PERIOD idle cycles
    always_comb begin
        idle_cnt_d = '0;
        w_refresh  = 1'b0;
        if ((state_q == S_IDLE) && !w_go_trig) begin
            if (idle_cnt_q == c_IDLE_LAST) begin
                w_refresh = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    // Idle counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    // Periodic refresh is compiled out; the period value has no effect
    assign w_refresh = (REFRESH_PERIOD < 0);
`endif

    // Print-pass FSM next state, dirty tracking, burst and ack-timeout counters
    always_comb begin
        state_d   = state_q;
        dirty_d   = dirty_q;
        trg_d     = 1'b0;
        burst_d   = burst_q;
        ack_cnt_d = ack_cnt_q;
        last_b_d  = last_b_q;

        if (w_we) begin
            dirty_d  = 1'b1;
            last_b_d = b_gnt;
            if (burst_q < c_BURST_MAX) begin
                burst_d = burst_q + 1'b1;
            end
        end
        if (w_refresh) begin
            dirty_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_go_trig) begin
                    state_d = S_TRIG;
                    trg_d   = 1'b1;
                    burst_d = '0;
                end
            end
            S_TRIG: begin
                dirty_d   = 1'b0;
                ack_cnt_d = '0;
                state_d   = S_ACK;
            end
            S_ACK: begin
                if (lcd_busy) begin
                    state_d = S_DONE;
                end else if (ack_cnt_q == c_ACK_LAST) begin
                    // Driver never answered: keep the content pending and retry
                    dirty_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!lcd_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame buffer write port
    always_comb begin
        mem_d = mem_q;
        if (w_we) begin
            mem_d[w_waddr] = w_wdata;
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            dirty_q   <= 1'b1;
            trg_q     <= 1'b0;
            burst_q   <= '0;
            ack_cnt_q <= '0;
            last_b_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            dirty_q   <= dirty_d;
            trg_q     <= trg_d;
            burst_q   <= burst_d;
            ack_cnt_q <= ack_cnt_d;
            last_b_q  <= last_b_d;
        end
    end

    // Frame buffer storage; reset clears the screen to spaces
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                mem_q[i] <= c_SPACE;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign lcd_trg  = trg_q;
    assign dirty    = dirty_q;
    assign lcd_data = mem_q[lcd_addr];

endmodule
`default_nettype wire
